// File: rtl/ast_packet_src.sv
// ast_packet_src: Avalon-ST packet generator producing incrementing-symbol packets of a commanded length.
module ast_packet_src #(
    parameter int AST_DWIDTH = 64,
    parameter int BITS_PER_SYMB = 8,
    parameter int CHANNEL_WIDTH = 1,
    parameter int LEN_WIDTH = 16,
    localparam int SPW = AST_DWIDTH / BITS_PER_SYMB,
    localparam int EMPTY_WIDTH = (SPW > 1) ? $clog2(SPW) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [LEN_WIDTH-1:0]     cmd_len_i,
    input  logic [CHANNEL_WIDTH-1:0] cmd_channel_i,
    input  logic [BITS_PER_SYMB-1:0] cmd_seed_i,
    output logic [AST_DWIDTH-1:0]    src_data_o,
    output logic                     src_valid_o,
    input  logic                     src_ready_i,
    output logic                     src_startofpacket_o,
    output logic                     src_endofpacket_o,
    output logic [EMPTY_WIDTH-1:0]   src_empty_o,
    output logic [CHANNEL_WIDTH-1:0] src_channel_o,
    output logic                     busy_o,
    output logic [31:0]              pkt_cnt_o
);
    localparam logic [LEN_WIDTH-1:0] SPW_L = LEN_WIDTH'(SPW);
    localparam logic [BITS_PER_SYMB-1:0] SPW_S = BITS_PER_SYMB'(SPW);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                     state, state_d;
    logic [LEN_WIDTH-1:0]       rem, rem_d, ld_rem;
    logic [BITS_PER_SYMB-1:0]   sym, sym_d, ld_sym;
    logic [AST_DWIDTH-1:0]      beat_data, data_d;
    logic [EMPTY_WIDTH-1:0]     beat_empty, empty_d;
    logic [CHANNEL_WIDTH-1:0]   channel_d;
    logic [31:0]                cnt_d;
    logic                       beat_eop, valid_d, sop_d, eop_d, ready_d, busy_d;
    logic                       accept, load, done;

    // A zero-length command is consumed in IDLE without starting a packet.
    assign accept = state == IDLE && cmd_ready_o && cmd_valid_i && cmd_len_i != '0;
    assign load   = accept || (state == SEND && src_ready_i && !src_endofpacket_o);
    assign done   = state == SEND && src_ready_i && src_endofpacket_o;

    // Format the next beat from either the new command or the running symbol/remaining state.
    always_comb begin
        ld_rem = accept ? cmd_len_i : rem;
        ld_sym = accept ? cmd_seed_i : sym;
        beat_data = '0;
        for (int j = 0; j < SPW; j++)
            beat_data[AST_DWIDTH-1-j*BITS_PER_SYMB -: BITS_PER_SYMB] =
                (LEN_WIDTH'(j) < ld_rem) ? ld_sym + BITS_PER_SYMB'(j) : '0;
        beat_eop = ld_rem <= SPW_L;
        beat_empty = beat_eop ? EMPTY_WIDTH'(SPW_L - ld_rem) : '0;
    end

    // Next-state and registered-output values; every src_* output holds while stalled.
    always_comb begin
        state_d   = accept ? SEND : done ? IDLE : state;
        ready_d   = state_d == IDLE;
        busy_d    = state_d == SEND;
        valid_d   = state_d == SEND;
        sop_d     = load ? accept : done ? 1'b0 : src_startofpacket_o;
        eop_d     = load ? beat_eop : done ? 1'b0 : src_endofpacket_o;
        empty_d   = load ? beat_empty : done ? '0 : src_empty_o;
        data_d    = load ? beat_data : done ? '0 : src_data_o;
        channel_d = accept ? cmd_channel_i : src_channel_o;
        sym_d     = load ? ld_sym + SPW_S : sym;
        rem_d     = load ? (beat_eop ? '0 : ld_rem - SPW_L) : rem;
        cnt_d     = done ? pkt_cnt_o + 32'd1 : pkt_cnt_o;
    end

    // State, counters and all outputs registered; reset truncates any packet in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= IDLE;
            rem                 <= '0;
            sym                 <= '0;
            cmd_ready_o         <= 1'b0;
            busy_o              <= 1'b0;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            src_empty_o         <= '0;
            src_data_o          <= '0;
            src_channel_o       <= '0;
            pkt_cnt_o           <= '0;
        end else begin
            state               <= state_d;
            rem                 <= rem_d;
            sym                 <= sym_d;
            cmd_ready_o         <= ready_d;
            busy_o              <= busy_d;
            src_valid_o         <= valid_d;
            src_startofpacket_o <= sop_d;
            src_endofpacket_o   <= eop_d;
            src_empty_o         <= empty_d;
            src_data_o          <= data_d;
            src_channel_o       <= channel_d;
            pkt_cnt_o           <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ast_packet_src.sv
// tb_ast_packet_src: directed and randomized checks of ast_packet_src against a beat-queue model.
module tb_ast_packet_src;
    logic        clk_i = 1'b0, rst_n_i = 1'b1;
    logic        cmd_valid_i = 1'b0, src_ready_i = 1'b0;
    logic [15:0] cmd_len_i = '0;
    logic [7:0]  cmd_seed_i = '0;
    logic [0:0]  cmd_channel_i = '0;
    logic        cmd_ready_o, src_valid_o, src_startofpacket_o, src_endofpacket_o, busy_o;
    logic [63:0] src_data_o;
    logic [2:0]  src_empty_o;
    logic [0:0]  src_channel_o;
    logic [31:0] pkt_cnt_o;

    ast_packet_src dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
        .cmd_channel_i(cmd_channel_i), .cmd_seed_i(cmd_seed_i),
        .src_data_o(src_data_o), .src_valid_o(src_valid_o), .src_ready_i(src_ready_i),
        .src_startofpacket_o(src_startofpacket_o), .src_endofpacket_o(src_endofpacket_o),
        .src_empty_o(src_empty_o), .src_channel_o(src_channel_o),
        .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        ch;
    } beat_t;

    beat_t       q[$];
    logic [31:0] cnt_m = '0;
    bit          armed = 1'b0;
    int          checks = 0, errors = 0, xfers = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected beats of one packet: symbol k = seed + k, first symbol in the top lane, unused lanes zero.
    function automatic void push_cmd(input int len, input logic [7:0] seed, input logic ch);
        int nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t t;
            t.data = '0;
            for (int l = 0; l < 8; l++)
                if (b * 8 + l < len) t.data[63-8*l -: 8] = seed + 8'(b * 8 + l);
            t.sop = b == 0;
            t.eop = b == nb - 1;
            t.empty = t.eop ? 3'(nb * 8 - len) : 3'd0;
            t.ch = ch;
            q.push_back(t);
        end
    endfunction

    // One clock: check outputs against the model at the falling edge, drive inputs, advance the model.
    task automatic step(input bit r, input bit v, input int len, input logic [7:0] seed, input bit ch, input bit rdy);
        bit ev;
        @(negedge clk_i);
        ev = q.size() != 0;
        check("valid", src_valid_o, ev);
        check("busy", busy_o, ev);
        check("cmd_ready", cmd_ready_o, !ev && armed);
        check("pkt_cnt", pkt_cnt_o, cnt_m);
        if (ev) begin
            check("data", src_data_o, q[0].data);
            check("sop", src_startofpacket_o, q[0].sop);
            check("eop", src_endofpacket_o, q[0].eop);
            check("empty", src_empty_o, q[0].empty);
            check("channel", src_channel_o, q[0].ch);
        end else begin
            check("sop_idle", src_startofpacket_o, 1'b0);
            check("eop_idle", src_endofpacket_o, 1'b0);
        end
        if (ev && rdy && r) xfers++;
        rst_n_i = r;
        cmd_valid_i = v;
        cmd_len_i = 16'(len);
        cmd_seed_i = seed;
        cmd_channel_i = ch;
        src_ready_i = rdy;
        if (!r) begin
            #1;
            check("rst_valid", src_valid_o, 1'b0);
            check("rst_cnt", pkt_cnt_o, 32'd0);
            check("rst_ready", cmd_ready_o, 1'b0);
            q.delete();
            cnt_m = '0;
            armed = 1'b0;
        end else begin
            if (ev && rdy) begin
                if (q[0].eop) cnt_m++;
                void'(q.pop_front());
            end else if (!ev && armed && v && len > 0) begin
                push_cmd(len, seed, ch);
            end
            armed = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) step(1, 0, 0, 8'h00, 0, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("drain_busy", busy_o, 1'b0);
    endtask

    bit rdy_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        #1 rst_n_i = 1'b0;
        repeat (3) step(0, 0, 0, 8'h00, 0, 0);
        step(1, 0, 0, 8'h00, 0, 1);
        // single full beat
        step(1, 1, 8, 8'h00, 1, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t1_data", src_data_o, 64'h0001020304050607);
        check("t1_sop_eop", {src_startofpacket_o, src_endofpacket_o}, 2'b11);
        check("t1_empty", src_empty_o, 3'd0);
        check("t1_channel", src_channel_o, 1'b1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t1_cnt", pkt_cnt_o, 32'd1);
        // two beats with symbol wrap and partial last beat
        step(1, 1, 13, 8'hFE, 0, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t2_b0_data", src_data_o, 64'hFEFF000102030405);
        check("t2_b0_sop", src_startofpacket_o, 1'b1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t2_b1_data", src_data_o, 64'h060708090A000000);
        check("t2_b1_eop", src_endofpacket_o, 1'b1);
        check("t2_b1_empty", src_empty_o, 3'd3);
        step(1, 1, 5, 8'h40, 0, 1);
        check("t2_gap_ready", cmd_ready_o, 1'b1);
        check("t2_gap_valid", src_valid_o, 1'b0);
        drain();
        // backpressure
        step(1, 1, 24, 8'h00, 0, 1);
        xfers = 0;
        for (int i = 0; i < 7; i++) step(1, 0, 0, 8'h00, 0, rdy_pat[i]);
        check("t3_beats", xfers, 3);
        drain();
        // zero-length command then one-symbol packet
        step(1, 1, 0, 8'h33, 1, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t4_cnt_held", pkt_cnt_o, 32'd4);
        step(1, 1, 1, 8'h55, 0, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t4_empty", src_empty_o, 3'd7);
        check("t4_data", src_data_o, 64'h5500000000000000);
        drain();
        // reset in the middle of a packet
        step(1, 1, 20, 8'h10, 1, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        step(1, 1, 5, 8'hA0, 0, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t5_sop", src_startofpacket_o, 1'b1);
        drain();
        // back-to-back packets
        xfers = 0;
        repeat (9) step(1, 1, 9, 8'h20, 0, 1);
        check("t6_beats", xfers, 6);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t6_cnt", pkt_cnt_o, 32'd4);
        // counter wrap
        force dut.pkt_cnt_o = 32'hFFFFFFFF;
        cnt_m = 32'hFFFFFFFF;
        step(1, 0, 0, 8'h00, 0, 1);
        release dut.pkt_cnt_o;
        step(1, 1, 4, 8'h77, 1, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        step(1, 0, 0, 8'h00, 0, 1);
        check("t7_wrap", pkt_cnt_o, 32'd0);
        // randomized traffic with random backpressure
        repeat (400)
            step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), 8'($urandom),
                 1'($urandom), $urandom_range(0, 3) != 0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
